// File: rtl/ppu_stream_ctrl.sv
// ---------------------------------------------------------------------------
// PpuStreamCtrl (module ppu_stream_ctrl)
//
// Initiator side of the PPU interface. Accepts a valid/ready stream of
// accumulated psums, steers each psum (plus pooling-window control) into the
// PPU, captures the PPU's 8-bit result per output pixel, packs four results
// little-endian into a 32-bit word and writes the words to the output GLB
// through a valid/ready write port with byte strobes.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_start                 one-cycle pulse, latches i_cfg_* (ignored while busy)
//   i_cfg_pool_en           1 = maxpool mode, 0 = bypass
//   i_cfg_pool_size         psums per pooling window (0 behaves as 1)
//   i_cfg_out_count         output bytes for the layer
//   i_cfg_base_addr         GLB byte address of the first output word
//   i_in_valid/o_in_ready   psum stream handshake, i_in_data = psum
//   o_ppu_data_in           psum forwarded combinationally to the PPU
//   o_ppu_maxpool_en/init   PPU comparator update / restart
//   o_ppu_relu_sel          latched pool enable
//   i_ppu_data_out          PPU 8-bit result
//   o_wr_valid/i_wr_ready   GLB write handshake
//   o_wr_addr/o_wr_data/o_wr_strb  write address, packed data, byte enables
//   o_busy                  layer in progress
//   o_done                  one-cycle pulse after the final write handshake
// ---------------------------------------------------------------------------
module ppu_stream_ctrl #(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 32,
    parameter int CNT_BITS  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_cfg_pool_en,
    input  logic [3:0]           i_cfg_pool_size,
    input  logic [CNT_BITS-1:0]  i_cfg_out_count,
    input  logic [ADDR_BITS-1:0] i_cfg_base_addr,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [DATA_BITS-1:0] i_in_data,
    output logic [DATA_BITS-1:0] o_ppu_data_in,
    output logic                 o_ppu_maxpool_en,
    output logic                 o_ppu_maxpool_init,
    output logic                 o_ppu_relu_sel,
    input  logic [7:0]           i_ppu_data_out,
    output logic                 o_wr_valid,
    input  logic                 i_wr_ready,
    output logic [ADDR_BITS-1:0] o_wr_addr,
    output logic [31:0]          o_wr_data,
    output logic [3:0]           o_wr_strb,
    output logic                 o_busy,
    output logic                 o_done
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ACCEPT    = 3'd1,
        POOL_WAIT = 3'd2,
        WRITE     = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_pool_en;
    logic [3:0]            r_pool_size;
    logic [CNT_BITS-1:0]   r_out_count;
    logic [ADDR_BITS-1:0]  r_base_addr;
    logic [3:0]            r_win_cnt;
    logic [1:0]            r_byte_idx;
    logic [CNT_BITS-1:0]   r_bytes_done;
    logic [CNT_BITS-1:0]   r_word_idx;
    logic [31:0]           r_pack;
    logic                  r_wr_valid;
    logic [ADDR_BITS-1:0]  r_wr_addr;
    logic [31:0]           r_wr_data;
    logic [3:0]            r_wr_strb;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_accept;
    logic [3:0]            w_pool_last;
    logic                  w_win_last;
    logic                  w_capture;
    logic [31:0]           w_pack_next;
    logic [CNT_BITS-1:0]   w_bytes_next;
    logic                  w_word_full;
    logic [ADDR_BITS-1:0]  w_word_addr;
    logic [3:0]            w_strb;

    // A psum is consumed only in ACCEPT; the PPU comparator is touched only on
    // that handshake cycle so input stalls never disturb the running max.
    assign w_accept           = (r_state == ACCEPT) && i_in_valid;
    assign o_in_ready         = (r_state == ACCEPT);
    assign o_ppu_data_in      = i_in_data;
    assign o_ppu_maxpool_en   = w_accept && r_pool_en;
    assign o_ppu_maxpool_init = w_accept && r_pool_en && (r_win_cnt == 4'd0);
    assign o_ppu_relu_sel     = r_pool_en;

    // A pool size of 0 behaves like a window of one psum.
    assign w_pool_last = (r_pool_size == 4'd0) ? 4'd0 : (r_pool_size - 4'd1);
    assign w_win_last  = (r_win_cnt == w_pool_last);

    // Bypass captures the combinational PPU result on the accept itself; pool
    // mode captures the registered max in the single POOL_WAIT cycle.
    assign w_capture    = (w_accept && !r_pool_en) || (r_state == POOL_WAIT);
    assign w_pack_next  = r_pack | (32'(i_ppu_data_out) << {r_byte_idx, 3'b000});
    assign w_bytes_next = r_bytes_done + 1'b1;
    assign w_word_full  = (r_byte_idx == 2'd3) || (w_bytes_next == r_out_count);
    assign w_word_addr  = r_base_addr + ADDR_BITS'({r_word_idx, 2'b00});

    // Strobe covers the lanes filled so far, including the one being captured.
    always_comb begin
        w_strb = 4'b0001;
        case (r_byte_idx)
            2'd0:    w_strb = 4'b0001;
            2'd1:    w_strb = 4'b0011;
            2'd2:    w_strb = 4'b0111;
            default: w_strb = 4'b1111;
        endcase
    end

    assign o_wr_valid = r_wr_valid;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;
    assign o_wr_strb  = r_wr_strb;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

    // Control FSM with registered write-port and status outputs. The byte
    // capture at the end overrides the state chosen by the case statement,
    // because a captured byte always decides between WRITE and ACCEPT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_pool_en    <= 1'b0;
            r_pool_size  <= 4'd0;
            r_out_count  <= '0;
            r_base_addr  <= '0;
            r_win_cnt    <= 4'd0;
            r_byte_idx   <= 2'd0;
            r_bytes_done <= '0;
            r_word_idx   <= '0;
            r_pack       <= 32'd0;
            r_wr_valid   <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= 32'd0;
            r_wr_strb    <= 4'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_pool_en    <= i_cfg_pool_en;
                        r_pool_size  <= i_cfg_pool_size;
                        r_out_count  <= i_cfg_out_count;
                        r_base_addr  <= i_cfg_base_addr;
                        r_win_cnt    <= 4'd0;
                        r_byte_idx   <= 2'd0;
                        r_bytes_done <= '0;
                        r_word_idx   <= '0;
                        r_pack       <= 32'd0;
                        if (i_cfg_out_count == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ACCEPT;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ACCEPT: begin
                    if (w_accept && r_pool_en) begin
                        if (w_win_last) begin
                            r_state <= POOL_WAIT;
                        end else begin
                            r_win_cnt <= r_win_cnt + 4'd1;
                        end
                    end
                end
                POOL_WAIT: begin
                    r_win_cnt <= 4'd0;
                end
                WRITE: begin
                    if (i_wr_ready) begin
                        r_wr_valid <= 1'b0;
                        r_word_idx <= r_word_idx + 1'b1;
                        r_byte_idx <= 2'd0;
                        r_pack     <= 32'd0;
                        if (r_bytes_done == r_out_count) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ACCEPT;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            if (w_capture) begin
                r_pack       <= w_pack_next;
                r_byte_idx   <= r_byte_idx + 2'd1;
                r_bytes_done <= w_bytes_next;
                if (w_word_full) begin
                    r_state    <= WRITE;
                    r_wr_valid <= 1'b1;
                    r_wr_data  <= w_pack_next;
                    r_wr_addr  <= w_word_addr;
                    r_wr_strb  <= w_strb;
                end else begin
                    r_state <= ACCEPT;
                end
            end
        end
    end

endmodule

// File: doc/ppu_stream_ctrl.md
Name: ppu_stream_ctrl

Overview:
- Initiator side of the PPU interface.
- Accepts a valid/ready stream of accumulated psums and drives each psum, with pooling-window control, into the PPU.
- Captures the PPU's 8-bit result per output pixel and packs four results little-endian into 32-bit words.
- Writes the words to the output GLB through a valid/ready write port with byte strobes.

Parameters:
- DATA_BITS, 32, psum width; equals PPU data_in width.
- ADDR_BITS, 32, GLB byte-address width.
- CNT_BITS, 16, width of the output-byte counter.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; latches cfg_*; ignored while busy=1
- cfg_pool_en  input  1  1 = maxpool mode (PPU relu_sel=1), 0 = bypass
- cfg_pool_size  input  4  psums per pooling window; 0 treated as 1
- cfg_out_count  input  CNT_BITS  number of output bytes for the layer
- cfg_base_addr  input  ADDR_BITS  GLB byte address of the first output word
- in_valid  input  1  psum valid
- in_ready  output  1  psum accepted when in_valid&&in_ready
- in_data  input  DATA_BITS  psum
- ppu_data_in  output  DATA_BITS  equals in_data, combinational
- ppu_maxpool_en  output  1  PPU comparator update
- ppu_maxpool_init  output  1  PPU comparator restart
- ppu_relu_sel  output  1  equals latched cfg_pool_en
- ppu_data_out  input  8  PPU result
- wr_valid  output  1  write request
- wr_ready  input  1  GLB accepts the write
- wr_addr  output  ADDR_BITS  word address: base + 4*word_idx
- wr_data  output  32  packed bytes; byte n in bits [8n+7:8n]
- wr_strb  output  4  byte enables
- busy  output  1  high from the cycle after start until done
- done  output  1  one-cycle pulse after the final write handshake

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, all counters and the pack register cleared.
- Reset mid-operation aborts immediately: no done pulse, and any partially packed word is discarded.
- PPU contract:
  - The comparator register loads its input on maxpool_init&&maxpool_en.
  - It takes the max on maxpool_en alone.
  - ppu_data_out is the registered max when relu_sel=1, and combinational when relu_sel=0.
- FSM states: IDLE, ACCEPT, POOL_WAIT, WRITE, DONE.
- IDLE:
  - start → ACCEPT, latching config.
  - If cfg_out_count==0, go to DONE instead; no writes are issued.
- ACCEPT:
  - in_ready=1.
  - ppu_maxpool_en and ppu_maxpool_init are asserted only in the same cycle as the accept handshake, so stalls never alter comparator state.
- Bypass mode (cfg_pool_en=0):
  - Each accepted psum captures ppu_data_out in the same cycle into byte lane byte_idx.
  - Latency from input to byte capture: 0 cycles.
- Pool mode:
  - A window counter counts accepted psums, 0..pool_size-1.
  - Element 0 asserts init+en; the other elements assert en.
  - On the last element → POOL_WAIT.
  - POOL_WAIT lasts one cycle: in_ready=0, ppu_data_out is captured, and the window counter is cleared.
  - in_valid gaps within a window are allowed.
- After each byte capture:
  - byte_idx increments and bytes_done increments.
  - If byte_idx reaches 3 or bytes_done==cfg_out_count → WRITE; otherwise stay in or return to ACCEPT.
- WRITE:
  - in_ready=0 and wr_valid=1.
  - wr_data, wr_addr and wr_strb are held stable until wr_ready.
  - Strobe is 4'b1111 for a full word, and ones only in the filled low lanes for the final partial word.
  - Unfilled lanes carry 0.
  - On handshake: word_idx++ and byte_idx=0, then → DONE if the layer is finished, else → ACCEPT.
  - If wr_ready is already high on the first WRITE cycle, the handshake completes in that cycle.
- DONE: done=1 for one cycle, busy falls, → IDLE.
- busy is 1 in ACCEPT, POOL_WAIT and WRITE.
- start during busy has no effect.
- Psums offered after the layer is finished are not accepted (in_ready=0 outside ACCEPT).

Test Plan:
- Bypass, count=8, 8 psums back-to-back, PPU model returns 0x01..0x08 → two writes: addr base with data 0x04030201 strb F, then base+4 with 0x08070605 strb F; done one cycle after the second handshake.
- Pool, size=4, count=2, psums whose quantized values are 3, 9, 1, 7 then 2, 2, 5, 0 → init asserted on the 1st and 5th accepts only, one POOL_WAIT per window, single write data=0x00000509 strb 4'b0011.
- Bypass, count=5 with wr_ready held low 6 cycles on each write → in_ready=0 and wr_* stable throughout; second write strb 4'b0001, data upper lanes zero.
- Pool, size=2, in_valid toggling every other cycle → maxpool_en/init pulse only on handshake cycles; the pooled result matches a reference max.
- start with cfg_out_count=0 → no wr_valid, done pulses within 2 cycles; a second start while busy is ignored.
- rst asserted during WRITE → all outputs 0 asynchronously; a following start runs a fresh layer from cfg_base_addr.
